// File: rtl/mode_ctrl_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mode_ctrl_arbiter_pkg
// Shared definitions for the mode-control arbiter slice:
//   - state_t         : arbiter FSM states (IDLE, LOAD, RUN, HOLD)
//   - UP1/UP2/DN1/DN2 : CONTROL codes understood by the shared counter
//   - DEFAULT_QUANTUM : default maximum RUN cycles per grant
//   - wrap_inc()      : circular increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package mode_ctrl_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    localparam logic [1:0] UP1 = 2'b00;
    localparam logic [1:0] UP2 = 2'b01;
    localparam logic [1:0] DN1 = 2'b10;
    localparam logic [1:0] DN2 = 2'b11;

    localparam int DEFAULT_QUANTUM = 4;

    // (idx + 1) mod n without a divider.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mode_ctrl_arbiter_if.sv
// -----------------------------------------------------------------------------
// mode_ctrl_arbiter_if
// Bundle between the requesters/counter side and the arbiter.
//   master : requester/counter side (drives req*, winner, loser, gameover)
//   slave  : arbiter side (drives gnt, control, init, load, busy, evt_*)
// Signals:
//   req       [N_REQ]     request level per requester
//   req_ctrl  [2*N_REQ]   requested CONTROL code per requester
//   req_init  [N_REQ]     requester wants a preload first
//   req_load  [4*N_REQ]   preload value per requester
//   winner/loser/gameover status pulses from the counter
//   gnt       [N_REQ]     one-hot grant
//   control   [2]         mode to the counter
//   init                  preload strobe
//   load      [4]         preload value
//   busy                  high in LOAD or RUN
//   evt_valid/evt_owner/evt_win  boundary-event report
// -----------------------------------------------------------------------------
interface mode_ctrl_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] req_ctrl;
    logic [N_REQ-1:0]   req_init;
    logic [4*N_REQ-1:0] req_load;
    logic               winner;
    logic               loser;
    logic               gameover;

    logic [N_REQ-1:0]   gnt;
    logic [1:0]         control;
    logic               init;
    logic [3:0]         load;
    logic               busy;
    logic               evt_valid;
    logic [IDX_W-1:0]   evt_owner;
    logic               evt_win;

    modport master (
        output req, req_ctrl, req_init, req_load, winner, loser, gameover,
        input  gnt, control, init, load, busy, evt_valid, evt_owner, evt_win
    );

    modport slave (
        input  req, req_ctrl, req_init, req_load, winner, loser, gameover,
        output gnt, control, init, load, busy, evt_valid, evt_owner, evt_win
    );

endinterface

// File: rtl/mode_ctrl_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// mode_ctrl_arbiter_rr_pick
// Combinational round-robin picker: returns the first set bit of req at or
// after rr_ptr, wrapping circularly.
// Ports:
//   req    [N_REQ]  request vector
//   rr_ptr [IDX_W]  search start index
//   idx    [IDX_W]  selected index (0 when nothing found)
//   found           at least one request is set
// -----------------------------------------------------------------------------
module mode_ctrl_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // Walk candidates in priority order starting at rr_ptr; the first hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// mode_ctrl_arbiter
// Round-robin arbiter granting N_REQ requesters time-sliced ownership of a
// shared up/down counter. An owner optionally preloads the counter (LOAD, one
// cycle) and then drives its CONTROL code for up to QUANTUM cycles (RUN).
// WINNER/LOSER end the slice early and are reported as a one-cycle event;
// GAMEOVER forces a one-cycle HOLD and restarts round-robin search at 0.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mode_ctrl_arbiter_if.slave (requests, counter status, grant outputs)
// All outputs are registered.
// -----------------------------------------------------------------------------
module mode_ctrl_arbiter
    import mode_ctrl_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int QUANTUM = DEFAULT_QUANTUM
) (
    input  logic                  clk,
    input  logic                  rst,
    mode_ctrl_arbiter_if.slave    bus
);

    localparam int         IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] RUN_LAST = 4'(QUANTUM - 1);

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [1:0]       owner_ctrl;
    logic [3:0]       run_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [1:0]       pick_ctrl;
    logic [3:0]       pick_load;
    logic             pick_init;
    logic             run_exit;
    logic             status_hit;

    mode_ctrl_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Per-requester fields of the candidate picked this cycle.
    always_comb begin
        pick_ctrl = UP1;
        pick_load = 4'h0;
        pick_init = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_ctrl = bus.req_ctrl[2*i +: 2];
                pick_load = bus.req_load[4*i +: 4];
                pick_init = bus.req_init[i];
            end
        end
    end

    assign status_hit = bus.winner | bus.loser;

    // The cycle in which any exit condition holds is the last RUN cycle.
    assign run_exit = (run_cnt == RUN_LAST) || !bus.req[owner] || status_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            owner_ctrl    <= UP1;
            run_cnt       <= 4'h0;
            bus.gnt       <= '0;
            bus.control   <= UP1;
            bus.init      <= 1'b0;
            bus.load      <= 4'h0;
            bus.busy      <= 1'b0;
            bus.evt_valid <= 1'b0;
            bus.evt_owner <= '0;
            bus.evt_win   <= 1'b0;
        end else begin
            // Status is only meaningful while an owner holds the counter.
            if ((state == ST_LOAD || state == ST_RUN) && status_hit) begin
                bus.evt_valid <= 1'b1;
                bus.evt_owner <= owner;
                bus.evt_win   <= bus.winner;
            end else begin
                bus.evt_valid <= 1'b0;
            end

            if (bus.gameover) begin
                // GAMEOVER preempts everything, from any state.
                state    <= ST_HOLD;
                bus.gnt  <= '0;
                bus.init <= 1'b0;
                bus.busy <= 1'b0;
                rr_ptr   <= '0;
                run_cnt  <= 4'h0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pick_found) begin
                            owner      <= pick_idx;
                            owner_ctrl <= pick_ctrl;
                            bus.gnt    <= to_onehot(pick_idx);
                            bus.busy   <= 1'b1;
                            run_cnt    <= 4'h0;
                            if (pick_init) begin
                                state    <= ST_LOAD;
                                bus.init <= 1'b1;
                                bus.load <= pick_load;
                            end else begin
                                state       <= ST_RUN;
                                bus.control <= pick_ctrl;
                            end
                        end else begin
                            bus.gnt <= '0;
                        end
                    end

                    ST_LOAD: begin
                        state       <= ST_RUN;
                        bus.init    <= 1'b0;
                        bus.control <= owner_ctrl;
                        run_cnt     <= 4'h0;
                    end

                    ST_RUN: begin
                        if (run_exit) begin
                            // Drop to IDLE for one cycle so owners never overlap.
                            state    <= ST_IDLE;
                            bus.gnt  <= '0;
                            bus.busy <= 1'b0;
                            rr_ptr   <= IDX_W'(wrap_inc(int'(owner), N_REQ));
                            run_cnt  <= 4'h0;
                        end else begin
                            run_cnt <= run_cnt + 4'd1;
                        end
                    end

                    ST_HOLD: begin
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mode_ctrl_arbiter.sv
module tb_mode_ctrl_arbiter;

    localparam int N = 4;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mode_ctrl_arbiter_if #(.N_REQ(N)) bus ();

    mode_ctrl_arbiter #(
        .N_REQ   (N),
        .QUANTUM (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         owner;
        int         len;
        logic [1:0] ctrl;
        bit         init;
        logic [3:0] load;
        int         gap;
    } grant_t;

    typedef struct {
        int owner;
        bit win;
    } evt_t;

    grant_t gq[$];
    evt_t   eq[$];
    int     total;
    int     bad;

    initial begin
        total = 0;
        bad   = 0;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_grant(input int owner, input int len, input logic [1:0] ctrl,
                              input bit init, input logic [3:0] load, input int gap);
        grant_t g;
        g.owner = owner; g.len = len; g.ctrl = ctrl;
        g.init = init; g.load = load; g.gap = gap;
        gq.push_back(g);
    endtask

    task automatic push_evt(input int owner, input bit win);
        evt_t e;
        e.owner = owner; e.win = win;
        eq.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gnt"},       int'(bus.gnt),       0);
        check({tag, "_control"},   int'(bus.control),   0);
        check({tag, "_init"},      int'(bus.init),      0);
        check({tag, "_load"},      int'(bus.load),      0);
        check({tag, "_busy"},      int'(bus.busy),      0);
        check({tag, "_evt_valid"}, int'(bus.evt_valid), 0);
        check({tag, "_evt_owner"}, int'(bus.evt_owner), 0);
        check({tag, "_evt_win"},   int'(bus.evt_win),   0);
    endtask

    // Monitor: pops expected grants/events as the DUT presents them.
    initial begin : monitor
        bit         in_g;
        int         len;
        int         gap;
        int         init_cnt;
        int         ctrl_bad;
        logic [3:0] load_obs;
        grant_t     cur;
        evt_t       ce;
        in_g = 0; len = 0; gap = 0; init_cnt = 0; ctrl_bad = 0; load_obs = 4'h0;
        cur = '{owner: -1, len: 0, ctrl: 2'b00, init: 1'b0, load: 4'h0, gap: -1};
        forever begin
            @(negedge clk);
            check("gnt_onehot0", int'($onehot0(bus.gnt)), 1);
            if (bus.gnt != '0) begin
                if (!in_g) begin
                    in_g = 1; len = 0; init_cnt = 0; ctrl_bad = 0;
                    if (gq.size() == 0) begin
                        check("unexpected_grant", int'(bus.gnt), 0);
                        cur = '{owner: -1, len: 0, ctrl: 2'b00, init: 1'b0, load: 4'h0, gap: -1};
                    end else begin
                        cur = gq.pop_front();
                        check("grant_owner", int'(bus.gnt), 1 << cur.owner);
                        if (cur.gap >= 0) check("grant_gap", gap, cur.gap);
                    end
                end
                len++;
                if (bus.init) begin
                    init_cnt++;
                    load_obs = bus.load;
                end else if (bus.control != cur.ctrl) begin
                    ctrl_bad++;
                end
            end else begin
                if (in_g) begin
                    in_g = 0;
                    check("grant_len", len, cur.len);
                    check("grant_init_cycles", init_cnt, cur.init ? 1 : 0);
                    if (cur.init) check("grant_load", int'(load_obs), int'(cur.load));
                    check("grant_ctrl_bad_cycles", ctrl_bad, 0);
                    gap = 0;
                end
                gap++;
            end
            if (bus.evt_valid) begin
                if (eq.size() == 0) begin
                    check("unexpected_evt", int'(bus.evt_valid), 0);
                end else begin
                    ce = eq.pop_front();
                    check("evt_owner", int'(bus.evt_owner), ce.owner);
                    check("evt_win", int'(bus.evt_win), int'(ce.win));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_ctrl = '0;
        bus.req_init = '0;
        bus.req_load = '0;
        bus.winner   = 1'b0;
        bus.loser    = 1'b0;
        bus.gameover = 1'b0;

        cycles(1);
        check_reset("rst_init");
        cycles(1);
        rst = 1'b0;

        // Single requester 2, code 01, no preload: two full slices with a gap.
        bus.req_ctrl = 8'b00_01_00_00;
        bus.req      = 4'b0100;
        push_grant(2, 4, 2'b01, 0, 4'h0, -1);
        push_grant(2, 4, 2'b01, 0, 4'h0, 1);
        cycles(10);
        bus.req = 4'b0000;
        cycles(3);

        // All four requesting from rr_ptr 0: 0,1,2,3,0.
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        bus.req_ctrl = 8'b11_10_01_00;
        bus.req      = 4'b1111;
        push_grant(0, 4, 2'b00, 0, 4'h0, -1);
        push_grant(1, 4, 2'b01, 0, 4'h0, 1);
        push_grant(2, 4, 2'b10, 0, 4'h0, 1);
        push_grant(3, 4, 2'b11, 0, 4'h0, 1);
        push_grant(0, 4, 2'b00, 0, 4'h0, 1);
        cycles(25);
        bus.req = 4'b0000;
        cycles(3);

        // Preload for requester 1, WINNER in RUN; inputs change mid-grant.
        bus.req_ctrl = 8'b11_10_00_00;
        bus.req_load = 16'h00E0;
        bus.req_init = 4'b0010;
        bus.req      = 4'b0010;
        push_grant(1, 2, 2'b00, 1, 4'hE, -1);
        push_evt(1, 1);
        cycles(1);
        bus.req_ctrl = 8'b11_10_11_00;
        bus.req_load = 16'h0050;
        cycles(1);
        bus.winner = 1'b1;
        cycles(1);
        bus.winner   = 1'b0;
        bus.req      = 4'b0000;
        bus.req_init = 4'b0000;
        check("busy_after_win", int'(bus.busy), 0);
        cycles(3);
        check("load_hold", int'(bus.load), 14);

        // WINNER and LOSER together: one event, win=1.
        bus.req_ctrl = 8'b11_10_11_10;
        bus.req      = 4'b0001;
        push_grant(0, 1, 2'b10, 0, 4'h0, -1);
        push_evt(0, 1);
        cycles(1);
        bus.winner = 1'b1;
        bus.loser  = 1'b1;
        cycles(1);
        bus.winner = 1'b0;
        bus.loser  = 1'b0;
        bus.req    = 4'b0000;
        cycles(3);
        check("ctrl_hold", int'(bus.control), 2);

        // LOSER alone for requester 3.
        bus.req_ctrl = 8'b01_10_11_10;
        bus.req      = 4'b1000;
        push_grant(3, 2, 2'b01, 0, 4'h0, -1);
        push_evt(3, 0);
        cycles(2);
        bus.loser = 1'b1;
        cycles(1);
        bus.loser = 1'b0;
        bus.req   = 4'b0000;
        cycles(2);

        // Status pulses while idle are ignored.
        bus.winner = 1'b1;
        bus.loser  = 1'b1;
        cycles(1);
        bus.winner = 1'b0;
        bus.loser  = 1'b0;
        cycles(2);

        // GAMEOVER during RUN of owner 3.
        bus.req_ctrl = 8'b11_10_01_00;
        bus.req      = 4'b1000;
        push_grant(3, 2, 2'b11, 0, 4'h0, -1);
        push_grant(0, 4, 2'b00, 0, 4'h0, 2);
        cycles(2);
        bus.gameover = 1'b1;
        cycles(1);
        bus.gameover = 1'b0;
        bus.req      = 4'b0001;
        check("hold_gnt", int'(bus.gnt), 0);
        check("hold_busy", int'(bus.busy), 0);
        cycles(6);
        bus.req = 4'b0000;
        cycles(3);

        // GAMEOVER held two cycles during owner 1: search restarts at 0, not 2.
        bus.req = 4'b0010;
        push_grant(1, 1, 2'b01, 0, 4'h0, -1);
        push_grant(0, 4, 2'b00, 0, 4'h0, 3);
        cycles(1);
        bus.gameover = 1'b1;
        bus.req      = 4'b0111;
        cycles(1);
        check("hold1_gnt", int'(bus.gnt), 0);
        cycles(1);
        bus.gameover = 1'b0;
        check("hold2_gnt", int'(bus.gnt), 0);
        cycles(2);
        bus.req = 4'b0001;
        check("post_hold_pick", int'(bus.gnt), 1);
        cycles(4);
        bus.req = 4'b0000;
        cycles(3);

        // Asynchronous reset mid-RUN with WINNER pending: no event.
        bus.req = 4'b0010;
        push_grant(1, 1, 2'b01, 0, 4'h0, -1);
        cycles(2);
        #2;
        rst        = 1'b1;
        bus.winner = 1'b1;
        #1;
        check_reset("rst_async");
        cycles(2);
        bus.winner = 1'b0;
        bus.req    = 4'b0100;
        push_grant(2, 4, 2'b10, 0, 4'h0, -1);
        rst = 1'b0;
        cycles(1);
        check("first_grant_after_rst", int'(bus.gnt), 4);
        check("first_ctrl_after_rst", int'(bus.control), 2);
        cycles(3);
        bus.req = 4'b0000;
        cycles(3);

        check("grant_queue_left", gq.size(), 0);
        check("evt_queue_left", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mode_ctrl_arbiter.md
MODE_CTRL_ARBITER -- requirements
Module: mode_ctrl_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing the counter (2..8).
REQ-002 Parameter: QUANTUM, default 4, maximum RUN cycles per grant (1..15).
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RST  in  1  asynchronous reset, active-high.
REQ-005 req  in  N_REQ  request bit per requester; level, held until granted or abandoned.
REQ-006 req_ctrl  in  2*N_REQ  requested CONTROL code per requester (00 +1, 01 +2, 10 -1, 11 -2).
REQ-007 req_init  in  N_REQ  requester wants a preload before counting.
REQ-008 req_load  in  4*N_REQ  preload value per requester.
REQ-009 WINNER, LOSER, GAMEOVER  in  1 each  status pulses from the counter.
REQ-010 gnt  out  N_REQ  one-hot grant; all-zero when no owner.
REQ-011 CONTROL  out  2  mode driven to the counter.
REQ-012 INIT  out  1  preload strobe to the counter.
REQ-013 load  out  4  preload value to the counter.
REQ-014 busy  out  1  high in LOAD or RUN.
REQ-015 evt_valid  out  1, evt_owner  out  clog2(N_REQ), evt_win  out  1: boundary-event report.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN and HOLD.
REQ-017 IDLE: if any req, grant the first set bit at or after rr_ptr (circular); latch owner, req_ctrl[owner] and req_load[owner]; go to LOAD if req_init[owner], else RUN.
REQ-018 IDLE with no req: stay; gnt=0.
REQ-019 LOAD: exactly 1 cycle; INIT=1, load=latched value, gnt[owner]=1; then RUN.
REQ-020 RUN: CONTROL=latched code, INIT=0, gnt[owner]=1; run counter increments each cycle.
REQ-021 RUN exits to IDLE after QUANTUM cycles, or earlier on the cycle req[owner] is 0, or on the cycle WINNER or LOSER is 1.
REQ-022 On any exit from RUN: rr_ptr = (owner+1) mod N_REQ and gnt=0 next cycle; there SHALL be a 1-cycle IDLE gap between owners.
REQ-023 Outside RUN, CONTROL SHALL hold its last value; INIT=0 outside LOAD; load holds its last value.
REQ-024 WINNER or LOSER sampled in LOAD or RUN SHALL produce evt_valid=1 for exactly one cycle, on the next cycle, with evt_owner=owner and evt_win=WINNER. WINNER has priority if both are 1.
REQ-025 WINNER or LOSER sampled in IDLE or HOLD SHALL be ignored.
REQ-026 GAMEOVER=1 in any state SHALL force HOLD on the next cycle, overriding REQ-021 and the normal flow, with gnt=0, INIT=0 and rr_ptr=0.
REQ-027 HOLD lasts 1 cycle, then goes to IDLE; a GAMEOVER that is still high re-enters HOLD.
REQ-028 Changes to req_ctrl or req_load during a grant SHALL NOT affect the latched values.
REQ-029 gnt SHALL never have more than one bit set.

Reset
REQ-030 RST=1 SHALL asynchronously force: state IDLE, gnt=0, CONTROL=00, INIT=0, load=0, busy=0, evt_valid=0, evt_owner=0, evt_win=0, rr_ptr=0, run counter 0.
REQ-031 Reset asserted mid-LOAD or mid-RUN SHALL abort the grant with no evt_valid pulse.
REQ-032 After reset release, the first grant is evaluated on the first rising edge.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the CONTROL code constants (UP1, UP2, DN1, DN2) and the default QUANTUM.
REQ-034 Round-robin selection SHALL be a sub-module, rr_pick: inputs req and rr_ptr; outputs the index and a found flag; purely combinational.

Verification
REQ-035 Single requester: req[2]=1, req_ctrl=01, no init -> gnt=0100 from cycle 1, CONTROL=01 for 4 cycles, then 1 IDLE cycle, then regrant of 2.
REQ-036 All four requesting, QUANTUM=4 -> grants rotate 0,1,2,3,0, each 4 RUN cycles plus a 1-cycle gap.
REQ-037 req_init[1]=1, req_load=1110, req_ctrl=00 -> one LOAD cycle with INIT=1 and load=1110; a WINNER pulse in RUN -> early release and evt_valid=1 with evt_owner=1 and evt_win=1.
REQ-038 LOSER and WINNER both 1 in RUN -> a single event with evt_win=1.
REQ-039 GAMEOVER pulse during RUN of owner 3 -> HOLD with gnt=0 next cycle, then IDLE, and the next grant starts search at index 0.
REQ-040 RST asserted mid-RUN, off the clock edge -> all outputs at reset values immediately, with no evt_valid.
